mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the ARM pipeline; sits directly upstream of the register file.
- Accepts EXE-stage results and performs LDR/STR through an external 16-bit SRAM using two half-word accesses per 32-bit word.
- Stalls the pipeline via ready while an access is in progress.
- Registers Result_WB, Dest_wb and writeBackEn for the register file.

Parameters:
- BASE_ADDR, 32'd1024, byte address mapped to SRAM word 0
- ADDR_W, 18, SRAM half-word address width
- WAIT_CYCLES, 2, cycles each half-word access is held; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- mem_r_en  in  1  load request from EXE
- mem_w_en  in  1  store request from EXE
- wb_en_in  in  1  instruction writes a register
- dest_in  in  4  destination register index
- alu_result  in  32  computed byte address, or ALU result for non-memory instructions
- st_val  in  32  store data (Rd value)
- ready  out  1  high means the pipeline may advance this cycle
- sram_addr  out  ADDR_W  half-word address
- sram_wdata  out  16  write data
- sram_rdata  in  16  read data
- sram_we_n  out  1  write strobe, active-low
- sram_oe_n  out  1  output enable, active-low
- Result_WB  out  32  write-back value
- Dest_wb  out  4  write-back register index
- writeBackEn  out  1  write-back enable

Behaviour:
- Reset values:
  - State IDLE, counter 0.
  - Result_WB=0, Dest_wb=0, writeBackEn=0.
  - sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_wdata=0.
  - Read-data holding register = 0.
- A reset asserted mid-access aborts the access at that edge. No WB update occurs and the strobes are deasserted in the next cycle.
- Request: req = mem_r_en | mem_w_en. If both are high, the load wins and the store is ignored.
- Address:
  - off = alu_result - BASE_ADDR, in 32-bit wrap-around arithmetic.
  - word = off[ADDR_W:2]; the lower two bits are ignored.
  - Low half uses sram_addr = {word, 1'b0}; high half uses {word, 1'b1}.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if req, go to LO with counter cleared; otherwise stay.
  - LO: count to WAIT_CYCLES-1, then go to HI.
  - HI: count to WAIT_CYCLES-1, then go to DONE.
  - DONE: go to IDLE unconditionally.
- Strobes are registered and driven during LO and HI.
  - Store: sram_we_n=0, sram_oe_n=1. sram_wdata = st_val[15:0] in LO, st_val[31:16] in HI.
  - Load: sram_oe_n=0, sram_we_n=1.
  - Outside LO and HI: both strobes high.
- Read capture: sram_rdata is sampled at the last LO cycle into bits [15:0] and at the last HI cycle into bits [31:16].
- ready (combinational) = !(IDLE & req) & !(LO | HI).
  - A memory instruction therefore holds ready low for 2*WAIT_CYCLES+1 cycles.
  - ready is high in DONE, which prevents a retrigger.
  - Inputs must stay stable while ready is low (the upstream pipeline is frozen).
- WB register, on each posedge with no reset:
  - If ready: writeBackEn <= wb_en_in; Dest_wb <= dest_in; Result_WB <= mem_r_en ? assembled read word : alu_result.
  - If not ready: writeBackEn <= 0 (bubble). Dest_wb and Result_WB hold.
- Non-memory instructions pass through with one-cycle latency and no stall.
- Back-to-back memory instructions: the second request is seen in IDLE on the cycle after DONE.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, LO, HI, DONE}
  - BASE_ADDR default
  - SRAM data width constant (16)
- Natural sub-module: sram_controller, containing the FSM, counter, strobes, address/data muxing and read assembly.
- mem_wb_stage keeps the ready logic and the WB register.

Test Plan:
- Reset, then an ALU op (alu_result=32'h55, dest_in=3, wb_en_in=1) -> ready stays 1; the next cycle shows Result_WB=32'h55, Dest_wb=3, writeBackEn=1.
- Store with alu_result=1024+8, st_val=32'hDEADBEEF, WAIT_CYCLES=2 -> ready low 5 cycles; sram_addr=4 with wdata 16'hBEEF for 2 cycles, then sram_addr=5 with wdata 16'hDEAD for 2 cycles; writeBackEn=0 afterwards.
- Load from the same address with an SRAM model -> Result_WB=32'hDEADBEEF, Dest_wb=dest_in, writeBackEn=1 after DONE; writeBackEn=0 throughout the stall.
- Back-to-back store then load to address 1024+12 -> second access starts the cycle after DONE; no duplicate WB pulse; data round-trips.
- rst asserted at the second HI cycle of a load -> state IDLE, strobes high, writeBackEn=0; no WB write for the aborted load.
- mem_r_en=mem_w_en=1 -> read performed, sram_we_n never low.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM/WB stage and its SRAM
// controller.
//   mem_state_e   : half-word access sequencer states
//   BASE_ADDR_DEF : byte address that maps to SRAM word 0
//   SRAM_DW       : SRAM data bus width
//   CNT_W         : wait-cycle counter width (WAIT_CYCLES up to 15)
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
    localparam int          SRAM_DW       = 16;
    localparam int          CNT_W         = 4;

    // Half-word SRAM address for a word index; hi selects the upper half.
    function automatic logic [31:0] half_addr(input logic [31:0] word, input logic hi);
        return {word[30:0], hi};
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: external 16-bit SRAM bus.
//   master : driven by the memory stage (address, write data, strobes),
//            receives read data
//   slave  : the SRAM device side
// Strobes are active-low.
interface mem_wb_stage_if #(
    parameter int ADDR_W = 18
);
    import mem_pkg::*;

    logic [ADDR_W-1:0]  sram_addr;
    logic [SRAM_DW-1:0] sram_wdata;
    logic [SRAM_DW-1:0] sram_rdata;
    logic               sram_we_n;
    logic               sram_oe_n;

    modport master (
        output sram_addr,
        output sram_wdata,
        output sram_we_n,
        output sram_oe_n,
        input  sram_rdata
    );

    modport slave (
        input  sram_addr,
        input  sram_wdata,
        input  sram_we_n,
        input  sram_oe_n,
        output sram_rdata
    );

endinterface

// File: rtl/mem_wb_stage_sram_controller.sv
// sram_controller: splits one 32-bit LDR/STR into two half-word SRAM
// accesses (low half first), each held for WAIT_CYCLES cycles.
//   clk, rst      : clock, synchronous active-high reset
//   req_i         : memory request (load or store)
//   load_i        : request is a load (wins over a simultaneous store)
//   alu_result_i  : byte address from EXE
//   st_val_i      : store data
//   bus           : SRAM bus (master side), all outputs registered
//   state_o       : sequencer state, used upstream for the stall signal
//   rd_word_o     : assembled 32-bit read word
// WAIT_CYCLES legal range is 1..15.
module sram_controller
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          ADDR_W      = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  load_i,
    input  logic [31:0]           alu_result_i,
    input  logic [31:0]           st_val_i,
    mem_wb_stage_if.master        bus,
    output mem_state_e            state_o,
    output logic [31:0]           rd_word_o
);

    logic [31:0]       off;
    logic [ADDR_W-2:0] word;
    logic [31:0]       word_ext;
    logic              last_cnt;

    mem_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_n_q;
    logic               oe_n_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [SRAM_DW-1:0] wdata_q;
    logic [31:0]        rd_q;

    // Wrap-around offset from the SRAM window base; byte lane bits dropped.
    assign off      = alu_result_i - BASE_ADDR;
    assign word     = off[ADDR_W:2];
    assign word_ext = 32'(word);
    assign last_cnt = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

    logic unused_off_bits;
    assign unused_off_bits = ^{off[31:ADDR_W+1], off[1:0]};

    // Strobes, address and write data are set on the edge that enters
    // LO/HI so they are valid for the whole access window. Inputs are
    // frozen upstream while the access runs, so they can be sampled in
    // any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        state_q <= LO;
                        cnt_q   <= '0;
                        we_n_q  <= load_i;
                        oe_n_q  <= !load_i;
                        addr_q  <= ADDR_W'(half_addr(word_ext, 1'b0));
                        wdata_q <= st_val_i[15:0];
                    end
                end
                LO: begin
                    if (last_cnt) begin
                        state_q     <= HI;
                        cnt_q       <= '0;
                        rd_q[15:0]  <= bus.sram_rdata;
                        addr_q      <= ADDR_W'(half_addr(word_ext, 1'b1));
                        wdata_q     <= st_val_i[31:16];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HI: begin
                    if (last_cnt) begin
                        state_q     <= DONE;
                        cnt_q       <= '0;
                        rd_q[31:16] <= bus.sram_rdata;
                        we_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.sram_we_n  = we_n_q;
    assign bus.sram_oe_n  = oe_n_q;
    assign state_o        = state_q;
    assign rd_word_o      = rd_q;

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory stage plus MEM/WB pipeline register.
//   clk, rst                 : clock, synchronous active-high reset
//   mem_r_en, mem_w_en       : load / store request from EXE
//   wb_en_in, dest_in        : register write-back control
//   alu_result               : byte address or ALU result
//   st_val                   : store data
//   ready                    : pipeline may advance this cycle
//   sram                     : SRAM bus (master)
//   Result_WB, Dest_wb,
//   writeBackEn              : registered write-back to the register file
// A memory instruction stalls for 2*WAIT_CYCLES+1 cycles; everything else
// passes with one cycle of latency.
module mem_wb_stage
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          ADDR_W      = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_r_en,
    input  logic            mem_w_en,
    input  logic            wb_en_in,
    input  logic [3:0]      dest_in,
    input  logic [31:0]     alu_result,
    input  logic [31:0]     st_val,
    output logic            ready,
    mem_wb_stage_if.master  sram,
    output logic [31:0]     Result_WB,
    output logic [3:0]      Dest_wb,
    output logic            writeBackEn
);

    logic        req;
    logic        ready_c;
    mem_state_e  state;
    logic [31:0] rd_word;

    logic [31:0] result_q;
    logic [3:0]  dest_q;
    logic        wben_q;

    assign req = mem_r_en | mem_w_en;

    sram_controller #(
        .BASE_ADDR   (BASE_ADDR),
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .load_i       (mem_r_en),
        .alu_result_i (alu_result),
        .st_val_i     (st_val),
        .bus          (sram),
        .state_o      (state),
        .rd_word_o    (rd_word)
    );

    // Low from the request cycle through the last HI cycle. High again in
    // DONE, so the same (still presented) request cannot retrigger.
    assign ready_c = !((state == IDLE) && req) && !((state == LO) || (state == HI));
    assign ready   = ready_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            dest_q   <= '0;
            wben_q   <= 1'b0;
        end else if (ready_c) begin
            wben_q   <= wb_en_in;
            dest_q   <= dest_in;
            result_q <= mem_r_en ? rd_word : alu_result;
        end else begin
            // Stall bubble: suppress the write, keep the last values.
            wben_q   <= 1'b0;
        end
    end

    assign Result_WB   = result_q;
    assign Dest_wb     = dest_q;
    assign writeBackEn = wben_q;

endmodule
